fir_tap_mac: RTL and testbench

- Time-multiplexed N-tap FIR section with a single multiplier.
- Consumes the sample stream after the WIDTH-bit delay pipeline in the ECS filter datapath.
- Holds its own tap history and a programmable coefficient bank.
- Produces one rounded, saturated filtered sample per accepted input, flagged by a one-cycle valid pulse.

---
 rtl/fir_tap_mac.sv | 154 +++++++++++++++
 tb/tb_fir_tap_mac.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_tap_mac.sv
// fir_tap_mac: time-multiplexed N-tap FIR section, one multiplier.
// Accept -> NTAPS MAC cycles -> round/saturate -> one-cycle valid pulse.
module fir_tap_mac #(
  parameter int WIDTH  = 16,
  parameter int COEF_W = 16,
  parameter int NTAPS  = 8,
  parameter int ACC_W  = 40,
  parameter int SHIFT  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  din,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic              coef_wr,
  input  logic [3:0]        coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  output logic [WIDTH-1:0]  dout,
  output logic              dout_valid
);

  localparam int IW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam int PW = WIDTH + COEF_W;

  localparam logic signed [ACC_W:0] HALF =
    (ACC_W+1)'(1) << (SHIFT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_OUT
  } state_t;

  state_t state_q, state_d;

  logic [IW-1:0]     idx_q, idx_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  dout_q, dout_d;
  logic              dv_q, dv_d;

  logic [WIDTH-1:0]  tap_q    [NTAPS];
  logic [WIDTH-1:0]  tap_d    [NTAPS];
  logic [COEF_W-1:0] shadow_q [NTAPS];
  logic [COEF_W-1:0] shadow_d [NTAPS];
  logic [COEF_W-1:0] act_q    [NTAPS];
  logic [COEF_W-1:0] act_d    [NTAPS];

  logic signed [PW-1:0]  prod;
  logic [ACC_W-1:0]      prod_ext;
  logic signed [ACC_W:0] rsum;
  logic signed [ACC_W:0] rsh;
  logic                  ovf;
  logic [WIDTH-1:0]      sat;
  logic                  addr_ok;

  assign din_ready  = (state_q == S_IDLE) && !rst;
  assign dout       = dout_q;
  assign dout_valid = dv_q;

  // Single multiplier: current tap times its snapshotted coefficient.
  always_comb begin
    prod = $signed(tap_q[idx_q]) * $signed(act_q[idx_q]);
    prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};
  end

  // Round half toward +inf, arithmetic shift, clamp to output range.
  always_comb begin
    rsum = $signed({acc_q[ACC_W-1], acc_q}) + HALF;
    rsh  = rsum >>> SHIFT;
    ovf  = !((&rsh[ACC_W:WIDTH-1]) || !(|rsh[ACC_W:WIDTH-1]));
    if (ovf) begin
      sat = rsh[ACC_W] ? {1'b1, {(WIDTH-1){1'b0}}}
                       : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      sat = rsh[WIDTH-1:0];
    end
  end

  assign addr_ok = ({1'b0, coef_addr} < 5'(NTAPS));

  // Next-state: FSM sequencing, tap shift, snapshot, MAC and output.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    dout_d   = dout_q;
    dv_d     = 1'b0;
    tap_d    = tap_q;
    act_d    = act_q;
    shadow_d = shadow_q;

    if (coef_wr && addr_ok) begin
      shadow_d[coef_addr[IW-1:0]] = coef_data;
    end

    unique case (state_q)
      S_IDLE: begin
        if (din_valid) begin
          tap_d[0] = din;
          for (int k = 1; k < NTAPS; k++) begin
            tap_d[k] = tap_q[k-1];
          end
          act_d   = shadow_q;
          acc_d   = '0;
          idx_d   = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_q + prod_ext;
        idx_d = idx_q + 1'b1;
        if (idx_q == IW'(NTAPS - 1)) begin
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        dout_d  = sat;
        dv_d    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset clearing all history.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      for (int k = 0; k < NTAPS; k++) begin
        tap_q[k]    <= '0;
        shadow_q[k] <= '0;
        act_q[k]    <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      for (int k = 0; k < NTAPS; k++) begin
        tap_q[k]    <= tap_d[k];
        shadow_q[k] <= shadow_d[k];
        act_q[k]    <= act_d[k];
      end
    end
  end

endmodule

// File: tb/tb_fir_tap_mac.sv
// tb_fir_tap_mac: scenario tasks checked against an arithmetic
// FIR model (tap list, shadow/active coefficient banks).
module tb_fir_tap_mac;

  localparam int W  = 16;
  localparam int CW = 16;
  localparam int NT = 8;
  localparam int AW = 40;
  localparam int SH = 15;
  localparam int P  = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  din = '0;
  logic          din_valid = 1'b0;
  logic          din_ready;
  logic          coef_wr = 1'b0;
  logic [3:0]    coef_addr = '0;
  logic [CW-1:0] coef_data = '0;
  logic [W-1:0]  dout;
  logic          dout_valid;

  int checks = 0;
  int failures = 0;
  int vcount = 0;
  bit prev_dv = 1'b0;

  int m_tap [NT];
  int m_sh  [NT];
  int m_act [NT];
  int exp_q;
  longint acc_t = 0;
  longint prev_acc_t = 0;

  fir_tap_mac #(
    .WIDTH (W),
    .COEF_W(CW),
    .NTAPS (NT),
    .ACC_W (AW),
    .SHIFT (SH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .coef_wr   (coef_wr),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .dout      (dout),
    .dout_valid(dout_valid)
  );

  always #(P/2) clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (prev_dv) begin
      checks++;
      if (dout_valid !== 1'b0) begin
        failures++;
        $display("FAIL pulse_width dout_valid=%b required 0", dout_valid);
      end
    end
    if (dout_valid === 1'b1) vcount++;
    prev_dv = (dout_valid === 1'b1);
  end

  function automatic int sx16(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  function automatic int ref_out();
    longint s = 0;
    longint r;
    for (int k = 0; k < NT; k++) begin
      s += longint'(m_tap[k]) * longint'(m_act[k]);
    end
    r = (s + (longint'(1) <<< (SH - 1))) >>> SH;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return int'(r);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NT; k++) begin
      m_tap[k] = 0;
      m_sh[k]  = 0;
      m_act[k] = 0;
    end
  endtask

  task automatic coef_write(input int a, input int d);
    coef_wr   = 1'b1;
    coef_addr = a[3:0];
    coef_data = d[15:0];
    @(negedge clk);
    coef_wr = 1'b0;
    if (a < NT) m_sh[a] = sx16(d[15:0]);
  endtask

  task automatic set_all(input int d);
    for (int k = 0; k < NT; k++) coef_write(k, d);
  endtask

  task automatic start_sample(input int s, input bit wr,
                              input int a, input int d);
    int n;
    din       = s[15:0];
    din_valid = 1'b1;
    if (wr) begin
      coef_wr   = 1'b1;
      coef_addr = a[3:0];
      coef_data = d[15:0];
    end
    n = 0;
    while (din_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 40) begin
      failures++;
      $display("FAIL accept_timeout din_ready=%b required 1", din_ready);
    end
    @(posedge clk);
    prev_acc_t = acc_t;
    acc_t = longint'($time);
    for (int k = NT - 1; k > 0; k--) m_tap[k] = m_tap[k-1];
    m_tap[0] = sx16(s[15:0]);
    m_act = m_sh;
    if (wr && a < NT) m_sh[a] = sx16(d[15:0]);
    exp_q = ref_out();
    @(negedge clk);
    din_valid = 1'b0;
    coef_wr   = 1'b0;
  endtask

  task automatic finish_sample(input string nm, output int got);
    int c;
    longint lat;
    c = 0;
    got = 0;
    while (dout_valid !== 1'b1 && c < 40) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (dout_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s_valid_timeout dout_valid=%b required 1",
               nm, dout_valid);
    end else begin
      got = sx16(dout);
      lat = (longint'($time) - acc_t - P/2) / P;
      checks++;
      if (lat != NT + 1) begin
        failures++;
        $display("FAIL %s_latency got=%0d required=%0d", nm, lat, NT + 1);
      end
      checks++;
      if (got !== exp_q) begin
        failures++;
        $display("FAIL %s_value got=%0d required=%0d", nm, got, exp_q);
      end
    end
  endtask

  task automatic test_reset();
    model_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (din_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready got=%b required 0", din_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (din_ready !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_ready got=%b required 1", din_ready);
    end
    repeat (10) begin
      @(negedge clk);
      checks++;
      if (dout !== 16'h0000) begin
        failures++;
        $display("FAIL reset_dout got=%h required 0000", dout);
      end
    end
    checks++;
    if (vcount != 0) begin
      failures++;
      $display("FAIL reset_no_valid got=%0d required 0", vcount);
    end
  endtask

  task automatic test_impulse();
    int got;
    int exp_tab [10] = '{500, 500, 500, 500, 500, 500, 500, 500, 0, 0};
    set_all('h4000);
    for (int i = 0; i < 10; i++) begin
      start_sample((i == 0) ? 1000 : 0, 1'b0, 0, 0);
      finish_sample("impulse", got);
      checks++;
      if (got != exp_tab[i]) begin
        failures++;
        $display("FAIL impulse_tab[%0d] got=%0d required=%0d",
                 i, got, exp_tab[i]);
      end
      if (i > 0) begin
        checks++;
        if (acc_t - prev_acc_t != (NT + 2) * P) begin
          failures++;
          $display("FAIL impulse_spacing got=%0d required=%0d",
                   acc_t - prev_acc_t, (NT + 2) * P);
        end
      end
    end
  endtask

  task automatic test_rounding();
    int got;
    int ins  [3] = '{3, -3, 1};
    int outs [3] = '{2, -1, 1};
    coef_write(0, 'h4000);
    for (int k = 1; k < NT; k++) coef_write(k, 0);
    for (int i = 0; i < 3; i++) begin
      start_sample(ins[i], 1'b0, 0, 0);
      finish_sample("round", got);
      checks++;
      if (got != outs[i]) begin
        failures++;
        $display("FAIL round_in%0d got=%0d required=%0d",
                 ins[i], got, outs[i]);
      end
    end
  endtask

  task automatic test_saturation();
    int got;
    set_all('h7FFF);
    for (int i = 0; i < NT; i++) begin
      start_sample(32767, 1'b0, 0, 0);
      finish_sample("sat_pos", got);
    end
    checks++;
    if (got != 32767) begin
      failures++;
      $display("FAIL sat_pos_final got=%0d required=32767", got);
    end
    for (int i = 0; i < NT; i++) begin
      start_sample(-32768, 1'b0, 0, 0);
      finish_sample("sat_neg", got);
    end
    checks++;
    if (got != -32768) begin
      failures++;
      $display("FAIL sat_neg_final got=%0d required=-32768", got);
    end
  endtask

  task automatic test_snapshot();
    int got;
    coef_write(0, 'h4000);
    for (int k = 1; k < NT; k++) coef_write(k, 0);
    start_sample(100, 1'b0, 0, 0);
    coef_write(0, 0);
    finish_sample("snap_mid", got);
    checks++;
    if (got != 50) begin
      failures++;
      $display("FAIL snap_inflight got=%0d required=50", got);
    end
    start_sample(100, 1'b0, 0, 0);
    finish_sample("snap_next", got);
    checks++;
    if (got != 0) begin
      failures++;
      $display("FAIL snap_next got=%0d required=0", got);
    end
    coef_write(0, 'h4000);
    start_sample(100, 1'b1, 0, 0);
    finish_sample("snap_same", got);
    checks++;
    if (got != 50) begin
      failures++;
      $display("FAIL snap_same_cycle got=%0d required=50", got);
    end
    start_sample(100, 1'b0, 0, 0);
    finish_sample("snap_after", got);
    checks++;
    if (got != 0) begin
      failures++;
      $display("FAIL snap_after got=%0d required=0", got);
    end
  endtask

  task automatic test_reset_mid();
    int got;
    int v0;
    set_all('h4000);
    start_sample(1000, 1'b0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    v0 = vcount;
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    checks++;
    if (vcount != v0) begin
      failures++;
      $display("FAIL abort_valid got=%0d required=%0d", vcount, v0);
    end
    checks++;
    if (dout !== 16'h0000) begin
      failures++;
      $display("FAIL abort_dout got=%h required 0000", dout);
    end
    set_all('h4000);
    start_sample(200, 1'b0, 0, 0);
    finish_sample("abort_next", got);
    checks++;
    if (got != 100) begin
      failures++;
      $display("FAIL abort_next got=%0d required=100", got);
    end
  endtask

  task automatic test_random();
    int got;
    int nw;
    for (int k = 0; k < NT; k++) coef_write(k, int'($urandom));
    for (int i = 0; i < 40; i++) begin
      start_sample(int'($urandom_range(0, 65535)),
                   ($urandom_range(0, 3) == 0),
                   int'($urandom_range(0, 15)),
                   int'($urandom));
      nw = int'($urandom_range(0, 3));
      repeat (nw) begin
        coef_write(int'($urandom_range(0, 15)), int'($urandom));
      end
      finish_sample("random", got);
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_rounding();
    test_saturation();
    test_snapshot();
    test_reset_mid();
    test_random();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
